// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IFU,
    BUSY_LSU,
    RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  localparam int unsigned DEFAULT_TIMEOUT   = 255;
  localparam int unsigned DEFAULT_CNT_WIDTH = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between IFU, LSU, the arbiter and the memory port.
interface mem_arbiter_if;
  logic        ifu_reqValid;
  logic        ifu_reqReady;
  logic [31:0] ifu_raddr;
  logic        ifu_respValid;
  logic [31:0] ifu_rdata;
  logic        ifu_respErr;

  logic        lsu_reqValid;
  logic        lsu_reqReady;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_respValid;
  logic [31:0] lsu_rdata;
  logic        lsu_respErr;

  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid;
  logic [31:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  ifu_reqValid, ifu_raddr,
    output ifu_reqReady, ifu_respValid, ifu_rdata, ifu_respErr,
    input  lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_reqReady, lsu_respValid, lsu_rdata, lsu_respErr,
    output mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_respValid, mem_rdata
  );

  // Requester / memory side
  modport master (
    output ifu_reqValid, ifu_raddr,
    input  ifu_reqReady, ifu_respValid, ifu_rdata, ifu_respErr,
    output lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_reqReady, lsu_respValid, lsu_rdata, lsu_respErr,
    input  mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_respValid, mem_rdata
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Saturating cycle counter that flags when a memory request has waited too long.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU fetches and LSU accesses,
// with a watchdog that turns a silent memory into an error response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_e  state, state_nxt;
  owner_e      rr_ptr, owner_q;
  logic [31:0] addr_q, wdata_q;
  logic        wen_q;
  logic [3:0]  wmask_q;
  logic [31:0] ifu_rdata_q, lsu_rdata_q;
  logic        err_q;

  logic        grant_ifu, grant_lsu;
  logic        accept_ifu, accept_lsu;
  logic        busy, expired, done;
  logic [31:0] resp_rdata;

  always_comb begin
    grant_ifu = bus.ifu_reqValid && (!bus.lsu_reqValid || (rr_ptr == OWN_IFU));
    grant_lsu = bus.lsu_reqValid && !grant_ifu;
  end

  // Readies are gated by rst so every output is low while reset is held.
  assign accept_ifu = rst && (state == IDLE) && grant_ifu;
  assign accept_lsu = rst && (state == IDLE) && grant_lsu;
  assign busy       = (state == BUSY_IFU) || (state == BUSY_LSU);
  // A memory response in the expiry cycle takes priority over the timeout.
  assign done       = busy && (bus.mem_respValid || expired);
  assign resp_rdata = (bus.mem_respValid && !wen_q) ? bus.mem_rdata : '0;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept_ifu || accept_lsu),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept_ifu) begin
          state_nxt = BUSY_IFU;
        end else if (accept_lsu) begin
          state_nxt = BUSY_LSU;
        end
      end
      BUSY_IFU, BUSY_LSU: begin
        if (done) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr      <= OWN_IFU;
      owner_q     <= OWN_IFU;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept_ifu) begin
        addr_q  <= bus.ifu_raddr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
        owner_q <= OWN_IFU;
        rr_ptr  <= OWN_LSU;
      end else if (accept_lsu) begin
        addr_q  <= bus.lsu_addr;
        wen_q   <= bus.lsu_wen;
        wdata_q <= bus.lsu_wdata;
        wmask_q <= bus.lsu_wmask;
        owner_q <= OWN_LSU;
        rr_ptr  <= OWN_IFU;
      end
      if (done) begin
        err_q <= !bus.mem_respValid;
        if (owner_q == OWN_IFU) begin
          ifu_rdata_q <= resp_rdata;
        end else begin
          lsu_rdata_q <= resp_rdata;
        end
      end
    end
  end

  assign bus.ifu_reqReady  = accept_ifu;
  assign bus.lsu_reqReady  = accept_lsu;
  assign bus.ifu_respValid = (state == RESP) && (owner_q == OWN_IFU);
  assign bus.lsu_respValid = (state == RESP) && (owner_q == OWN_LSU);
  assign bus.ifu_respErr   = bus.ifu_respValid && err_q;
  assign bus.lsu_respErr   = bus.lsu_respValid && err_q;
  assign bus.ifu_rdata     = ifu_rdata_q;
  assign bus.lsu_rdata     = lsu_rdata_q;

  assign bus.mem_reqValid  = busy;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model with programmable latency,
// expected responses queued at acceptance and checked when respValid pulses.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT_CYCLES (T),
    .CNT_WIDTH      (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    owner_e      own;
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mreq_t;

  resp_t  resp_q[$];
  mreq_t  mreq_q[$];
  owner_e grant_log[$];

  int unsigned tests = 0;
  int unsigned fails = 0;

  owner_e      rr_m;
  bit          busy_m, mem_active, spur, acc_ifu, acc_lsu;
  int unsigned cyc = 0;
  int unsigned mem_delay = 1;
  int unsigned mem_cnt;
  logic [31:0] mem_data = '0;
  logic [31:0] last_ifu, last_lsu;
  mreq_t       cur;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // mem_delay == n responds in the n-th cycle of mem_reqValid; 0 never responds.
  function automatic resp_t predict(input owner_e own, input logic wen);
    resp_t r;
    r.own   = own;
    r.err   = (mem_delay == 0) || (mem_delay > T + 1);
    r.rdata = (r.err || wen) ? 32'h0 : mem_data;
    r.cyc   = cyc + (r.err ? T + 2 : mem_delay + 1);
    return r;
  endfunction

  task automatic clear_model();
    resp_q.delete();
    mreq_q.delete();
    rr_m       = OWN_IFU;
    busy_m     = 0;
    mem_active = 0;
    spur       = 0;
    acc_ifu    = 0;
    acc_lsu    = 0;
    last_ifu   = '0;
    last_lsu   = '0;
    bus.mem_respValid = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  task automatic monitor_step();
    logic  exp_ir, exp_lr;
    resp_t r;
    mreq_t m;
    exp_ir = !busy_m && bus.ifu_reqValid && (!bus.lsu_reqValid || rr_m == OWN_IFU);
    exp_lr = !busy_m && bus.lsu_reqValid && !exp_ir;
    if (bus.ifu_reqValid || bus.lsu_reqValid)
      chk("req_ready", {bus.ifu_reqReady, bus.lsu_reqReady}, {exp_ir, exp_lr});

    if (bus.ifu_respValid || bus.lsu_respValid) begin
      if (resp_q.size() == 0) begin
        chk("spurious_resp", {bus.ifu_respValid, bus.lsu_respValid}, 2'b00);
      end else begin
        r = resp_q.pop_front();
        chk("resp_valid", {bus.ifu_respValid, bus.lsu_respValid},
            (r.own == OWN_IFU) ? 2'b10 : 2'b01);
        chk("resp_rdata", (r.own == OWN_IFU) ? bus.ifu_rdata : bus.lsu_rdata, r.rdata);
        chk("resp_err", (r.own == OWN_IFU) ? bus.ifu_respErr : bus.lsu_respErr, r.err);
        chk("resp_cycle", cyc, r.cyc);
        if (r.own == OWN_IFU) last_ifu = r.rdata;
        else                  last_lsu = r.rdata;
      end
      busy_m = 0;
    end

    if (bus.mem_reqValid) begin
      if (!mem_active) begin
        mem_active = 1;
        mem_cnt    = 0;
        if (mreq_q.size() == 0) chk("spurious_mem_req", bus.mem_reqValid, 1'b0);
        else                    cur = mreq_q.pop_front();
      end
      mem_cnt++;
      chk("mem_addr_wdata", {bus.mem_addr, bus.mem_wdata}, {cur.addr, cur.wdata});
      chk("mem_wen_wmask", {bus.mem_wen, bus.mem_wmask}, {cur.wen, cur.wmask});
      bus.mem_respValid = (mem_delay != 0) && (mem_cnt == mem_delay);
      bus.mem_rdata     = bus.mem_respValid ? mem_data : $urandom();
    end else begin
      mem_active        = 0;
      bus.mem_respValid = spur;
      bus.mem_rdata     = spur ? 32'hBAD0BAD0 : '0;
      spur              = 0;
    end

    if (bus.ifu_reqValid && bus.ifu_reqReady) begin
      m = '{addr: bus.ifu_raddr, wen: 1'b0, wdata: 32'h0, wmask: 4'h0};
      mreq_q.push_back(m);
      resp_q.push_back(predict(OWN_IFU, 1'b0));
      grant_log.push_back(OWN_IFU);
      rr_m = OWN_LSU; busy_m = 1; acc_ifu = 1;
    end else if (bus.lsu_reqValid && bus.lsu_reqReady) begin
      m = '{addr: bus.lsu_addr, wen: bus.lsu_wen, wdata: bus.lsu_wdata, wmask: bus.lsu_wmask};
      mreq_q.push_back(m);
      resp_q.push_back(predict(OWN_LSU, bus.lsu_wen));
      grant_log.push_back(OWN_LSU);
      rr_m = OWN_IFU; busy_m = 1; acc_lsu = 1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) monitor_step();
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {bus.ifu_reqReady, bus.ifu_respValid, bus.ifu_respErr,
                        bus.lsu_reqReady, bus.lsu_respValid, bus.lsu_respErr,
                        bus.mem_reqValid, bus.mem_wen, bus.mem_wmask}, '0);
    chk({tag, "_rdata"}, {bus.ifu_rdata, bus.lsu_rdata}, '0);
    chk({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, '0);
  endtask

  task automatic reset_and_check(input string tag);
    rst = 1'b0;
    clear_model();
    #1;
    check_outputs_zero(tag);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic issue_ifu(input logic [31:0] a);
    int unsigned n = 0;
    bus.ifu_raddr = a; bus.ifu_reqValid = 1'b1; acc_ifu = 0;
    while (!acc_ifu && n < 50) begin @(posedge clk); n++; end
    #1 bus.ifu_reqValid = 1'b0;
    if (!acc_ifu) chk("ifu_accept_timeout", acc_ifu, 1'b1);
  endtask

  task automatic issue_lsu(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] msk);
    int unsigned n = 0;
    bus.lsu_addr = a; bus.lsu_wen = w; bus.lsu_wdata = d; bus.lsu_wmask = msk;
    bus.lsu_reqValid = 1'b1; acc_lsu = 0;
    while (!acc_lsu && n < 50) begin @(posedge clk); n++; end
    #1 bus.lsu_reqValid = 1'b0;
    if (!acc_lsu) chk("lsu_accept_timeout", acc_lsu, 1'b1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((resp_q.size() != 0 || busy_m) && n < 100) begin @(posedge clk); n++; end
    if (n >= 100) chk("drain_timeout", resp_q.size(), 0);
    #1;
  endtask

  task automatic tie_test();
    int unsigned n = 0;
    grant_log.delete();
    mem_delay = 1; mem_data = 32'h0000_0093;
    bus.ifu_raddr = 32'h8000_0100;
    bus.lsu_addr  = 32'h8000_2000; bus.lsu_wen = 1'b0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    acc_ifu = 0; acc_lsu = 0;
    bus.ifu_reqValid = 1'b1; bus.lsu_reqValid = 1'b1;
    while (grant_log.size() < 3 && n < 100) begin
      @(posedge clk); n++; #1;
      if (acc_ifu) begin acc_ifu = 0; bus.ifu_raddr = bus.ifu_raddr + 32'd4; end
      if (acc_lsu) begin acc_lsu = 0; bus.lsu_addr  = bus.lsu_addr  + 32'd4; end
    end
    bus.ifu_reqValid = 1'b0; bus.lsu_reqValid = 1'b0;
    drain();
    chk("grant_count", grant_log.size(), 3);
    if (grant_log.size() >= 3)
      chk("grant_order", {grant_log[0], grant_log[1], grant_log[2]}, {OWN_IFU, OWN_LSU, OWN_IFU});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.ifu_reqValid = 1'b0; bus.ifu_raddr = '0;
    bus.lsu_reqValid = 1'b0; bus.lsu_addr = '0; bus.lsu_wen = 1'b0;
    bus.lsu_wdata = '0; bus.lsu_wmask = '0;
    bus.mem_respValid = 1'b0; bus.mem_rdata = '0;
    #3;
    reset_and_check("reset");

    // Single fetch, memory answers in the second request cycle
    @(posedge clk); #1;
    mem_delay = 2; mem_data = 32'h0000_0413;
    issue_ifu(32'h8000_0000);
    drain();

    // Ties from reset alternate starting with IFU
    reset_and_check("reset2");
    @(posedge clk); #1;
    tie_test();

    // Store: fields held until acknowledge, rdata returned as zero
    mem_delay = 3; mem_data = 32'hCAFE_F00D;
    issue_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    drain();

    // Silent memory times out, then a normal request proceeds
    mem_delay = 0;
    issue_lsu(32'h8000_1004, 1'b0, 32'h0, 4'h0);
    drain();
    mem_delay = 1; mem_data = 32'h0000_0013;
    issue_ifu(32'h8000_0008);
    drain();

    // Response on the expiry cycle wins over the timeout
    mem_delay = T + 1; mem_data = 32'h1234_5678;
    issue_ifu(32'h8000_000C);
    drain();

    // Reset while BUSY_LSU abandons the transaction
    mem_delay = 0;
    issue_lsu(32'h8000_3000, 1'b0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #2;
    reset_and_check("mid_reset");
    @(posedge clk); #1 spur = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", {bus.ifu_respValid, bus.lsu_respValid, bus.mem_reqValid}, 3'b000);
    chk("post_reset_rdata", {bus.ifu_rdata, bus.lsu_rdata}, {last_ifu, last_lsu});

    // Recovery, then rdata must hold across a stray memory pulse
    mem_delay = 1; mem_data = 32'h55AA_33CC;
    issue_lsu(32'h8000_3004, 1'b0, 32'h0, 4'h0);
    drain();
    spur = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rdata_hold", {bus.ifu_rdata, bus.lsu_rdata}, {last_ifu, last_lsu});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
